// File: rtl/psdram_pkg.sv
// Shared definitions for the PSDRAM readback path.
//   - dump_state_t : control FSM states of psdram_uart_dump
//   - rd_state_t   : states of the async read sequencer
//   - default ADDR_W / RD_WAIT / RECOVER values
//   - IDLE_CTRL / READ_CTRL : values of {nMemOE, nMemWR, nRamCE, nRamLB, nRamUB}
package psdram_pkg;

  localparam int ADDR_W_DFLT  = 23;
  localparam int RD_WAIT_DFLT = 7;
  localparam int RECOVER_DFLT = 1;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    LATCH,
    TX_LO,
    TX_HI,
    RECOV,
    FINISH
  } dump_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_BUSY
  } rd_state_t;

  // Control bit order: {nMemOE, nMemWR, nRamCE, nRamLB, nRamUB}
  localparam logic [4:0] IDLE_CTRL = 5'b11111;
  localparam logic [4:0] READ_CTRL = 5'b01000;

endpackage

// File: rtl/psdram_async_read.sv
// Async-mode PSDRAM single-word read sequencer.
//   clk, reset : clock, synchronous active-high reset
//   req        : level request; an access starts when idle and req is high
//   cancel     : drop an access in progress (controls high next edge, no ack)
//   mem_data   : PSDRAM read data, sampled only on the final wait cycle
//   ack        : high in the cycle whose edge latches the word
//   data       : latched word (valid from the edge after ack)
//   ctrl       : registered {nMemOE, nMemWR, nRamCE, nRamLB, nRamUB}
// The requester holds the address stable for the duration of req.
module psdram_async_read
  import psdram_pkg::*;
#(
  parameter int RD_WAIT = RD_WAIT_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        cancel,
  input  logic [15:0] mem_data,
  output logic        ack,
  output logic [15:0] data,
  output logic [4:0]  ctrl
);

  rd_state_t  st, st_n;
  logic [3:0] cnt;

  always_comb begin
    st_n = st;
    ack  = 1'b0;
    case (st)
      RD_IDLE: if (req && !cancel) st_n = RD_BUSY;
      RD_BUSY: begin
        if (cancel) begin
          st_n = RD_IDLE;
        end else if (cnt == '0) begin
          st_n = RD_IDLE;
          ack  = 1'b1;
        end
      end
      default: st_n = RD_IDLE;
    endcase
  end

  // Controls drop on the edge that enters RD_BUSY and rise on the edge that
  // leaves it, so they stay low for exactly RD_WAIT cycles on a full access.
  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= RD_IDLE;
      ctrl <= IDLE_CTRL;
      cnt  <= '0;
      data <= '0;
    end else begin
      st <= st_n;
      case (st)
        RD_IDLE: begin
          if (st_n == RD_BUSY) begin
            ctrl <= READ_CTRL;
            cnt  <= 4'(RD_WAIT - 1);
          end
        end
        RD_BUSY: begin
          if (st_n == RD_IDLE) ctrl <= IDLE_CTRL;
          if (ack) data <= mem_data;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ctrl <= IDLE_CTRL;
      endcase
    end
  end

endmodule

// File: rtl/psdram_uart_dump.sv
// Reads PSDRAM words start_addr..end_addr (inclusive) and streams each word
// to a UART transmitter as low byte then high byte.
//   clk, reset            : clock, synchronous active-high reset
//   start, abort          : begin a dump when idle / terminate a dump
//   start_addr, end_addr  : inclusive word range
//   nMemOE..nRamUB, MemAdr: PSDRAM async read interface (nMemWR always 1)
//   MemDataIn             : read data from the top-level mux
//   tx_data/valid/ready   : byte stream to the UART transmitter
//   busy, done            : dump in progress / one-cycle completion pulse
//   Digit                 : MemAdr[15:0] for the 7-segment display
module psdram_uart_dump
  import psdram_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DFLT,
  parameter int RD_WAIT = RD_WAIT_DFLT,
  parameter int RECOVER = RECOVER_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              nMemOE,
  output logic              nMemWR,
  output logic              nRamCE,
  output logic              nRamLB,
  output logic              nRamUB,
  output logic [ADDR_W-1:0] MemAdr,
  input  logic [15:0]       MemDataIn,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       Digit
);

  dump_state_t       state, state_n;
  logic [ADDR_W-1:0] end_q;
  logic              abort_q;
  logic [2:0]        rc;
  logic              rd_ack;
  logic [15:0]       rd_data;
  logic [4:0]        ctrl;
  logic              fire, last, abort_any;

  assign fire      = tx_valid && tx_ready;
  assign last      = (MemAdr == end_q);
  assign abort_any = abort || abort_q;

  psdram_async_read #(
    .RD_WAIT(RD_WAIT)
  ) u_rd (
    .clk     (clk),
    .reset   (reset),
    .req     (state == ACCESS),
    .cancel  (abort && (state == ACCESS)),
    .mem_data(MemDataIn),
    .ack     (rd_ack),
    .data    (rd_data),
    .ctrl    (ctrl)
  );

  assign {nMemOE, nMemWR, nRamCE, nRamLB, nRamUB} = ctrl;
  assign Digit = MemAdr[15:0];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (start) state_n = (start_addr > end_addr) ? FINISH : ACCESS;
      ACCESS: begin
        if (abort)       state_n = FINISH;
        else if (rd_ack) state_n = LATCH;
      end
      LATCH:  state_n = abort ? FINISH : TX_LO;
      TX_LO:  if (fire) state_n = abort_any ? FINISH : TX_HI;
      TX_HI:  if (fire) state_n = (abort_any || last) ? FINISH : RECOV;
      RECOV: begin
        if (abort)         state_n = FINISH;
        else if (rc == '0) state_n = ACCESS;
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // An abort seen during a byte handshake is remembered so the handshake can
  // complete first even when abort is only a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      MemAdr   <= '0;
      end_q    <= '0;
      abort_q  <= 1'b0;
      rc       <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_n;
      done  <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            MemAdr  <= start_addr;
            end_q   <= end_addr;
            busy    <= 1'b1;
            abort_q <= 1'b0;
          end
        end
        LATCH: begin
          if (!abort) begin
            tx_data  <= rd_data[7:0];
            tx_valid <= 1'b1;
          end
        end
        TX_LO: begin
          if (abort) abort_q <= 1'b1;
          if (fire) begin
            if (abort_any) tx_valid <= 1'b0;
            else           tx_data  <= rd_data[15:8];
          end
        end
        TX_HI: begin
          if (abort) abort_q <= 1'b1;
          if (fire) begin
            tx_valid <= 1'b0;
            if (!(abort_any || last)) begin
              MemAdr <= MemAdr + 1'b1;
              rc     <= 3'(RECOVER - 1);
            end
          end
        end
        RECOV:  if (rc != '0) rc <= rc - 1'b1;
        FINISH: begin
          busy    <= 1'b0;
          abort_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psdram_uart_dump.sv
// Scoreboard bench for psdram_uart_dump: expected bytes are queued from a
// range/memory model when a dump is issued; a negedge monitor pops and
// compares each accepted byte.
module tb_psdram_uart_dump;

  localparam int RD_WAIT = 7;

  logic        clk = 1'b0;
  logic        reset, start, abort, tx_ready;
  logic [22:0] start_addr, end_addr, MemAdr;
  logic        nMemOE, nMemWR, nRamCE, nRamLB, nRamUB;
  logic [15:0] MemDataIn, Digit;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, done;

  int tests = 0, fails = 0;
  logic [7:0] exp_q[$];
  int done_cnt = 0, ce_falls = 0, wr_low = 0, adr_zero = 0;
  int ready_mode = 0;  // 0: follow ready_man, 1: toggle every 3 cycles, 2: random
  logic ready_man = 1'b0;
  int ready_ctr = 0;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_ce = 1'b1;
  logic [7:0] prev_d = '0;

  always #5 clk = ~clk;

  psdram_uart_dump #(.ADDR_W(23), .RD_WAIT(RD_WAIT), .RECOVER(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .start_addr(start_addr), .end_addr(end_addr),
    .nMemOE(nMemOE), .nMemWR(nMemWR), .nRamCE(nRamCE), .nRamLB(nRamLB),
    .nRamUB(nRamUB), .MemAdr(MemAdr), .MemDataIn(MemDataIn),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .Digit(Digit)
  );

  function automatic logic [15:0] mem_word(input logic [22:0] a);
    case (a)
      23'h10:  return 16'hA55A;
      23'h20:  return 16'h0102;
      23'h21:  return 16'h0304;
      23'h22:  return 16'h0506;
      23'h23:  return 16'h0708;
      default: return a[15:0] ^ 16'hC3A5;
    endcase
  endfunction

  // Memory only drives valid data while the chip is selected for reading.
  always_comb MemDataIn = (!nRamCE && !nMemOE) ? mem_word(MemAdr) : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [22:0] a);
    logic [15:0] w;
    w = mem_word(a);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      ready_ctr++;
      case (ready_mode)
        1:       if (ready_ctr % 3 == 0) tx_ready = ~tx_ready;
        2:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = ready_man;
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_v  = 1'b0;
      prev_ce = nRamCE;
    end else begin
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_extra: got byte %0h expected none", tx_data);
        end else begin
          chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        end
      end
      if (prev_v && !prev_r) begin
        chk("hold_valid", {31'h0, tx_valid}, 32'h1);
        chk("hold_data", {24'h0, tx_data}, {24'h0, prev_d});
      end
      if (prev_ce && !nRamCE) ce_falls++;
      if (!nMemWR) wr_low++;
      if (done) done_cnt++;
      if (busy && MemAdr == '0) adr_zero++;
      prev_v  = tx_valid;
      prev_r  = tx_ready;
      prev_d  = tx_data;
      prev_ce = nRamCE;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {24'h0, nMemOE, nMemWR, nRamCE, nRamLB, nRamUB, tx_valid, busy, done},
        32'hF8);
    chk({tag, "_adr"}, {9'h0, MemAdr}, 32'h0);
    chk({tag, "_txd"}, {24'h0, tx_data}, 32'h0);
    chk({tag, "_digit"}, {16'h0, Digit}, 32'h0);
  endtask

  // Issue a dump and wait for done; fv/de are edge numbers (start edge = 0)
  // of the first tx_valid and of done, -1 if never seen.
  task automatic do_dump(input logic [22:0] s, input logic [22:0] e,
                         output int fv, output int de);
    int d0, words;
    words = 0;
    if (s <= e) begin
      for (logic [23:0] a = {1'b0, s}; a <= {1'b0, e}; a++) begin
        push_word(a[22:0]);
        words++;
      end
    end
    ce_falls   = 0;
    d0         = done_cnt;
    start_addr = s;
    end_addr   = e;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    fv = -1;
    de = -1;
    for (int n = 1; n <= 4000 && de < 0; n++) begin
      @(posedge clk);
      #1;
      if (fv < 0 && tx_valid) fv = n;
      if (done) de = n;
    end
    @(posedge clk);
    #1;
    chk("done_seen", {31'h0, de >= 0}, 32'h1);
    chk("done_pulses", done_cnt - d0, 32'd1);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("ce_reads", ce_falls, words);
    chk("busy_after", {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_done(input int d0, input string tag);
    for (int n = 0; n < 4000 && done_cnt == d0; n++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk({tag, "_done"}, done_cnt - d0, 32'd1);
    chk({tag, "_queue"}, exp_q.size(), 32'd0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    for (n = 0; n < 200 && !tx_valid; n++) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_valid_seen"}, {31'h0, tx_valid}, 32'h1);
  endtask

  initial begin
    int fv, de, d0, falls;
    logic pce;
    logic [22:0] s;
    reset = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    start_addr = '0; end_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    ready_man = 1'b1;
    @(posedge clk);
    #1;

    // Single word
    do_dump(23'h10, 23'h10, fv, de);
    chk("single_first_valid", fv, RD_WAIT + 2);
    chk("single_digit", {16'h0, Digit}, 32'h10);

    // Range with backpressure
    ready_mode = 1;
    do_dump(23'h20, 23'h23, fv, de);
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Empty range
    do_dump(23'd5, 23'd4, fv, de);
    chk("empty_no_valid", fv, -1);
    chk("empty_done_edge", de, 1);

    // Top of memory
    adr_zero = 0;
    do_dump(23'h7FFFFE, 23'h7FFFFF, fv, de);
    chk("top_adr_nonzero", adr_zero, 0);
    chk("top_end_adr", {9'h0, MemAdr}, 32'h7FFFFF);

    // Random ranges, random backpressure
    ready_mode = 2;
    for (int i = 0; i < 8; i++) begin
      s = 23'($urandom_range(0, 5000));
      do_dump(s, s + 23'($urandom_range(0, 4)), fv, de);
    end
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Abort during ACCESS of the second word
    push_word(23'h30);
    d0 = done_cnt;
    start_addr = 23'h30; end_addr = 23'h33; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    pce = nRamCE;
    falls = 0;
    for (int n = 0; n < 200 && falls < 2; n++) begin
      @(posedge clk);
      #1;
      if (pce && !nRamCE) falls++;
      pce = nRamCE;
    end
    chk("abort_acc_second_read", falls, 2);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_acc_ce_high", {31'h0, nRamCE}, 32'h1);
    chk("abort_acc_no_valid", {31'h0, tx_valid}, 32'h0);
    wait_done(d0, "abort_acc");

    // Abort during TX_LO: low byte only
    ready_man = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(mem_word(23'h40) & 16'h00FF);
    d0 = done_cnt;
    start_addr = 23'h40; end_addr = 23'h41; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_valid("abort_lo");
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    ready_man = 1'b1;
    wait_done(d0, "abort_lo");

    // Reset during TX_HI
    ready_man = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(mem_word(23'h50) & 16'h00FF);
    start_addr = 23'h50; end_addr = 23'h51; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_valid("rst_hi");
    ready_man = 1'b1;
    @(posedge clk);
    #1;
    ready_man = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_mid");
    reset = 1'b0;
    chk("rst_queue", exp_q.size(), 32'd0);
    ready_man = 1'b1;
    @(posedge clk);
    #1;
    do_dump(23'h10, 23'h10, fv, de);
    chk("rst_restart_first_valid", fv, RD_WAIT + 2);

    chk("nmemwr_never_low", wr_low, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
